pi_txn_frontend: RTL and testbench

Pi-side register front end of the CPLD, directly upstream of the 68k bus sequencer. It decodes strobed Pi GPIO register accesses (PI_A/PI_RD/PI_WR), builds the bus operation descriptor (rw, UDS/LDS), and hands it to the sequencer over a req/start/done handshake. It also owns the Pi-visible status word, the IPL change flag, a bus watchdog and sticky error flags.

---
 rtl/pi_txn_frontend.sv | 151 +++++++++++++++
 tb/tb_pi_txn_frontend.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pi_txn_frontend.sv
// rtl/pi_txn_frontend.sv - Pi register front end: strobe decode, bus descriptor handshake, status and watchdog
module pi_txn_frontend #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TO_WIDTH       = 13
) (
  input  logic        PI_CLK,
  input  logic        PI_RST,
  input  logic [1:0]  PI_A,
  input  logic        PI_RD,
  input  logic        PI_WR,
  input  logic [15:0] PI_D_IN,
  output logic [15:0] PI_D_OUT,
  output logic        PI_D_OE,
  output logic        BUS_REQ,
  output logic        BUS_RW,
  output logic        BUS_UDS_n,
  output logic        BUS_LDS_n,
  input  logic        BUS_START,
  input  logic        BUS_DONE,
  input  logic        BUS_BERR,
  input  logic [2:0]  IPL_IN,
  input  logic        IPL_SAMPLE,
  output logic        TXN_IN_PROGRESS,
  output logic        IPL_CHANGED,
  output logic [15:0] STATUS_CTRL
);

  typedef enum logic [1:0] {IDLE, ADDR, REQ, ACTIVE} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] rd_sync, wr_sync;
  logic                   rd_prev, wr_prev;
  logic                   rd_rise, wr_rise;
  logic [TO_WIDTH-1:0]    wd_cnt;
  logic [2:0]             ipl;
  logic                   a0, overrun, timeout, berr;

  always_ff @(posedge PI_CLK) begin
    if (PI_RST) begin
      rd_sync <= '0;
      wr_sync <= '0;
      rd_prev <= 1'b0;
      wr_prev <= 1'b0;
    end else begin
      rd_sync <= {rd_sync[SYNC_STAGES-2:0], PI_RD};
      wr_sync <= {wr_sync[SYNC_STAGES-2:0], PI_WR};
      rd_prev <= rd_sync[SYNC_STAGES-1];
      wr_prev <= wr_sync[SYNC_STAGES-1];
    end
  end

  assign rd_rise = rd_sync[SYNC_STAGES-1] & ~rd_prev;
  assign wr_rise = wr_sync[SYNC_STAGES-1] & ~wr_prev;
  assign PI_D_OE = PI_RD && (PI_A == 2'd3);

  logic wr_lo, wr_hi, wr_ctrl, rd_status, can_issue, on_bus;
  logic start_ok, done_ok, wd_expire, timeout_fire;
  logic [15:0] status_word;

  assign wr_lo     = wr_rise && (PI_A == 2'd1);
  assign wr_hi     = wr_rise && (PI_A == 2'd2);
  assign wr_ctrl   = wr_rise && (PI_A == 2'd3);
  assign rd_status = rd_rise && (PI_A == 2'd3);
  assign can_issue = (state == IDLE) || (state == ADDR);
  assign on_bus    = (state == REQ) || (state == ACTIVE);
  assign start_ok  = (state == REQ) && BUS_START;
  assign done_ok   = (state == ACTIVE) && BUS_DONE;
  // The budget runs from request to completion; a handshake on the expiry cycle beats the abort.
  assign wd_expire    = on_bus && (wd_cnt >= TO_WIDTH'(TIMEOUT_CYCLES - 1));
  assign timeout_fire = wd_expire && !start_ok && !done_ok;

  assign status_word = {ipl, IPL_CHANGED, overrun, timeout, berr,
                        state != IDLE, STATUS_CTRL[7:0]};

  always_ff @(posedge PI_CLK) begin
    if (PI_RST) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, ADDR: begin
        if (wr_hi)      state_nxt = REQ;
        else if (wr_lo) state_nxt = ADDR;
      end
      REQ: begin
        if (BUS_START)      state_nxt = ACTIVE;
        else if (wd_expire) state_nxt = IDLE;
      end
      ACTIVE: begin
        if (BUS_DONE)       state_nxt = IDLE;
        else if (wd_expire) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PI_CLK) begin
    if (PI_RST) begin
      BUS_REQ         <= 1'b0;
      BUS_RW          <= 1'b1;
      BUS_UDS_n       <= 1'b1;
      BUS_LDS_n       <= 1'b1;
      TXN_IN_PROGRESS <= 1'b0;
      IPL_CHANGED     <= 1'b0;
      STATUS_CTRL     <= '0;
      PI_D_OUT        <= '0;
      ipl             <= '0;
      a0              <= 1'b0;
      overrun         <= 1'b0;
      timeout         <= 1'b0;
      berr            <= 1'b0;
      wd_cnt          <= '0;
    end else begin
      if (can_issue && wr_lo) begin
        a0              <= PI_D_IN[0];
        TXN_IN_PROGRESS <= 1'b1;
      end
      if (can_issue && wr_hi) begin
        BUS_RW          <= PI_D_IN[9];
        BUS_UDS_n       <= PI_D_IN[8] ? a0 : 1'b0;
        BUS_LDS_n       <= PI_D_IN[8] ? ~a0 : 1'b0;
        BUS_REQ         <= 1'b1;
        TXN_IN_PROGRESS <= 1'b1;
        wd_cnt          <= '0;
      end else if (on_bus && (wd_cnt != '1)) begin
        wd_cnt <= wd_cnt + TO_WIDTH'(1);
      end
      if (start_ok) BUS_REQ <= 1'b0;
      if (done_ok || timeout_fire) begin
        BUS_REQ         <= 1'b0;
        TXN_IN_PROGRESS <= 1'b0;
        BUS_RW          <= 1'b1;
        BUS_UDS_n       <= 1'b1;
        BUS_LDS_n       <= 1'b1;
      end
      if (wr_ctrl)    STATUS_CTRL <= PI_D_IN;
      if (IPL_SAMPLE) ipl         <= IPL_IN;
      if (rd_status)  PI_D_OUT    <= status_word;
      // Sticky flags: a set on the read cycle outranks the read-clear.
      IPL_CHANGED <= (IPL_SAMPLE && (IPL_IN != ipl)) || (IPL_CHANGED && !rd_status);
      overrun     <= (on_bus && (wr_lo || wr_hi)) || (overrun && !rd_status);
      timeout     <= timeout_fire || (timeout && !rd_status);
      berr        <= ((state == ACTIVE) && BUS_BERR) || (berr && !rd_status);
    end
  end

endmodule

// File: tb/tb_pi_txn_frontend.sv
// tb/tb_pi_txn_frontend.sv - self-checking bench for pi_txn_frontend
module tb_pi_txn_frontend;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  pi_a;
  logic        pi_rd, pi_wr;
  logic [15:0] pi_d_in, pi_d_out, status_ctrl;
  logic        pi_d_oe, bus_req, bus_rw, bus_uds_n, bus_lds_n;
  logic        bus_start, bus_done, bus_berr, ipl_sample;
  logic [2:0]  ipl_in;
  logic        txn, ipl_changed;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pi_txn_frontend dut (
    .PI_CLK(clk), .PI_RST(rst), .PI_A(pi_a), .PI_RD(pi_rd), .PI_WR(pi_wr),
    .PI_D_IN(pi_d_in), .PI_D_OUT(pi_d_out), .PI_D_OE(pi_d_oe),
    .BUS_REQ(bus_req), .BUS_RW(bus_rw), .BUS_UDS_n(bus_uds_n), .BUS_LDS_n(bus_lds_n),
    .BUS_START(bus_start), .BUS_DONE(bus_done), .BUS_BERR(bus_berr),
    .IPL_IN(ipl_in), .IPL_SAMPLE(ipl_sample),
    .TXN_IN_PROGRESS(txn), .IPL_CHANGED(ipl_changed), .STATUS_CTRL(status_ctrl)
  );

  typedef struct {
    logic [15:0] lo_d;
    logic [15:0] hi_d;
    logic        rw;
    logic        uds_n;
    logic        lds_n;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pi_write(input logic [1:0] a, input logic [15:0] d);
    pi_a = a; pi_d_in = d; pi_wr = 1'b1;
    tick(5);
    pi_wr = 1'b0;
    tick(4);
  endtask

  task automatic pi_read(input logic [1:0] a);
    pi_a = a; pi_rd = 1'b1;
    tick(1);
    check("d_oe", pi_d_oe, a == 2'd3);
    tick(4);
    pi_rd = 1'b0;
    tick(4);
  endtask

  task automatic pulse_start();
    bus_start = 1'b1; tick(1); bus_start = 1'b0; tick(1);
  endtask

  task automatic pulse_done(input logic with_berr);
    bus_done = 1'b1; bus_berr = with_berr; tick(1);
    bus_done = 1'b0; bus_berr = 1'b0; tick(1);
  endtask

  task automatic pulse_ipl(input logic [2:0] v);
    ipl_in = v; ipl_sample = 1'b1; tick(1); ipl_sample = 1'b0; tick(1);
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(2); rst = 1'b0; tick(1);
  endtask

  // Reference lane selection: words use both lanes; a byte at an even address is the upper lane.
  function automatic logic [1:0] lanes_n(input logic is_byte, input logic odd);
    if (!is_byte) return 2'b00;
    return odd ? 2'b10 : 2'b01;
  endfunction

  logic [2:0]  m_ipl;
  logic        m_chg, m_berr;
  logic [15:0] m_ctrl;

  initial begin
    rst = 1'b1; pi_a = 0; pi_rd = 0; pi_wr = 0; pi_d_in = 0;
    bus_start = 0; bus_done = 0; bus_berr = 0; ipl_in = 0; ipl_sample = 0;

    vecs[0] = '{16'h0000, 16'h0200, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{16'h0001, 16'h0100, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{16'h0000, 16'h0100, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{16'h00A3, 16'h0300, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0};

    tick(3);
    rst = 1'b0;
    tick(1);
    check("rst_req", bus_req, 0);
    check("rst_rw", bus_rw, 1);
    check("rst_strobes", {bus_uds_n, bus_lds_n}, 2'b11);
    check("rst_txn", txn, 0);
    check("rst_iplc", ipl_changed, 0);
    check("rst_ctrl", status_ctrl, 0);
    check("rst_dout", pi_d_out, 0);

    for (int i = 0; i < 5; i++) begin
      pi_write(2'd1, vecs[i].lo_d);
      check("lo_txn", txn, 1);
      pi_write(2'd2, vecs[i].hi_d);
      check("vec_req", bus_req, 1);
      check("vec_rw", bus_rw, vecs[i].rw);
      check("vec_uds", bus_uds_n, vecs[i].uds_n);
      check("vec_lds", bus_lds_n, vecs[i].lds_n);
      pulse_start();
      check("vec_req_drop", bus_req, 0);
      check("vec_txn_active", txn, 1);
      pulse_done(1'b0);
      check("vec_txn_end", txn, 0);
      check("vec_idle_bus", {bus_rw, bus_uds_n, bus_lds_n}, 3'b111);
      pi_read(2'd3);
      check("vec_status", pi_d_out, 16'h0000);
    end

    // Watchdog abort when the sequencer never accepts.
    pi_write(2'd1, 16'h0000);
    pi_write(2'd2, 16'h0200);
    tick(3900);
    check("wd_not_yet", bus_req, 1);
    tick(300);
    check("wd_req", bus_req, 0);
    check("wd_txn", txn, 0);
    pi_read(2'd3);
    check("wd_status1", pi_d_out[10], 1);
    pi_read(2'd3);
    check("wd_status2", pi_d_out[10], 0);

    // Overrun: descriptor write while ACTIVE is rejected.
    pi_write(2'd1, 16'h0001);
    pi_write(2'd2, 16'h0100);
    pulse_start();
    pi_write(2'd2, 16'h0200);
    check("ovr_rw", bus_rw, 0);
    check("ovr_strobes", {bus_uds_n, bus_lds_n}, 2'b10);
    check("ovr_txn", txn, 1);
    pulse_done(1'b0);
    pi_read(2'd3);
    check("ovr_status", pi_d_out, 16'h0800);

    // IPL change flag, including a sample that coincides with the read.
    pi_write(2'd3, 16'h0002);
    check("ctrl", status_ctrl, 16'h0002);
    pulse_ipl(3'b101);
    check("ipl_chg", ipl_changed, 1);
    pi_read(2'd3);
    check("ipl_status", pi_d_out, 16'hB002);
    check("ipl_clr", ipl_changed, 0);
    pulse_ipl(3'b110);
    pi_a = 2'd3; pi_rd = 1'b1;
    tick(2);
    ipl_in = 3'b011; ipl_sample = 1'b1;
    tick(1);
    ipl_sample = 1'b0;
    tick(3);
    pi_rd = 1'b0;
    tick(4);
    check("ipl_race_snap", pi_d_out, 16'hD002);
    check("ipl_race_flag", ipl_changed, 1);
    pi_read(2'd3);
    check("ipl_after", pi_d_out, 16'h7002);

    // Reset while a cycle is on the bus.
    pi_write(2'd1, 16'h0000);
    pi_write(2'd2, 16'h0000);
    pulse_start();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("mid_rst_req", bus_req, 0);
    check("mid_rst_txn", txn, 0);
    check("mid_rst_ctrl", status_ctrl, 0);
    check("mid_rst_strobes", {bus_rw, bus_uds_n, bus_lds_n}, 3'b111);

    // Randomized traffic against a reference status model.
    do_reset();
    m_ipl = 0; m_chg = 0; m_berr = 0; m_ctrl = 0;
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          logic [15:0] lo, hi;
          logic        be;
          lo = 16'($urandom);
          hi = {6'b0, 2'($urandom), 8'($urandom)};
          be = 1'($urandom);
          pi_write(2'd1, lo);
          pi_write(2'd2, hi);
          check("rnd_req", bus_req, 1);
          check("rnd_rw", bus_rw, hi[9]);
          check("rnd_lanes", {bus_uds_n, bus_lds_n}, lanes_n(hi[8], lo[0]));
          pulse_start();
          pulse_done(be);
          check("rnd_txn", txn, 0);
          m_berr = m_berr | be;
        end
        1: begin
          logic [2:0] v;
          v = 3'($urandom);
          pulse_ipl(v);
          if (v != m_ipl) m_chg = 1'b1;
          m_ipl = v;
          check("rnd_iplc", ipl_changed, m_chg);
        end
        2: begin
          m_ctrl = 16'($urandom);
          pi_write(2'd3, m_ctrl);
          check("rnd_ctrl", status_ctrl, m_ctrl);
        end
        default: begin
          logic [15:0] exp;
          exp = {m_ipl, m_chg, 1'b0, 1'b0, m_berr, 1'b0, m_ctrl[7:0]};
          pi_read(2'd3);
          check("rnd_status", pi_d_out, exp);
          m_chg = 0; m_berr = 0;
        end
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
